// File: rtl/spi_reg_ctrl_pkg.sv
// Shared types and constants for the SPI register controller.
// FSM state enum, register address map and frame geometry.
package spi_reg_ctrl_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CNT_SAT    = FRAME_BITS + 1;
  localparam int CNT_W      = 5;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'd0;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'd1;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'd2;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'd3;
  localparam logic [6:0] ADDR_PWM_DUTY  = 7'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_e;

endpackage

// File: rtl/spi_reg_ctrl_sync_edge.sv
// Multi-flop synchronizer with rise/fall pulses for one async input.
// Ports: clk, rst (sync, active high), d_i raw input, q_o level, rise_o, fall_o.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic [STAGES:0]   vld_q, vld_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
    prev_d = sync_q[STAGES-1];
    vld_d  = {vld_q[STAGES-1:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      vld_q  <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      vld_q  <= vld_d;
    end
  end

  // Edges are suppressed until the chain and the delayed copy both hold
  // post-reset samples, so a line already away from its idle level at
  // reset release never looks like a fresh edge.
  assign q_o    = sync_q[STAGES-1];
  assign rise_o = vld_q[STAGES] & q_o & ~prev_q;
  assign fall_o = vld_q[STAGES] & ~q_o & prev_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI (mode 0) slave writing a bank of five 8-bit control registers.
// Ports: clk, rst, ncs_i/sclk_i/copi_i (async SPI), five register outputs,
// frame_done / frame_err one-cycle status pulses.
module spi_reg_ctrl
  import spi_reg_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ncs_i,
  input  logic       sclk_i,
  input  logic       copi_i,
  output logic [7:0] en_out_lo,
  output logic [7:0] en_out_hi,
  output logic [7:0] en_pwm_lo,
  output logic [7:0] en_pwm_hi,
  output logic [7:0] pwm_duty,
  output logic       frame_done,
  output logic       frame_err
);

  localparam logic [6:0]       MAX_A = 7'(MAX_ADDR);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(CNT_SAT);

  logic ncs_s, ncs_rise, ncs_fall;
  logic sclk_s, sclk_rise, sclk_fall;

  sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_ncs (
    .clk    (clk),
    .rst    (rst),
    .d_i    (ncs_i),
    .q_o    (ncs_s),
    .rise_o (ncs_rise),
    .fall_o (ncs_fall)
  );

  sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sclk (
    .clk    (clk),
    .rst    (rst),
    .d_i    (sclk_i),
    .q_o    (sclk_s),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  logic [SYNC_STAGES-1:0] copi_q, copi_d;
  logic                   copi_s;

  state_e           state_q, state_d;
  logic [15:0]      shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       r0_q, r0_d;
  logic [7:0]       r1_q, r1_d;
  logic [7:0]       r2_q, r2_d;
  logic [7:0]       r3_q, r3_d;
  logic [7:0]       r4_q, r4_d;

  logic       is_wr;
  logic [6:0] addr;
  logic [7:0] data;
  logic       frame_ok;
  logic       unused_ok;

  assign copi_s    = copi_q[SYNC_STAGES-1];
  assign is_wr     = shift_q[15];
  assign addr      = shift_q[14:8];
  assign data      = shift_q[7:0];
  assign frame_ok  = (cnt_q == CNT_FULL) && (addr <= MAX_A);
  assign unused_ok = ncs_s ^ sclk_s ^ sclk_fall;

  always_comb begin
    copi_d = {copi_q[SYNC_STAGES-2:0], copi_i};
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    r0_d       = r0_q;
    r1_d       = r1_q;
    r2_d       = r2_q;
    r3_d       = r3_q;
    r4_d       = r4_q;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ncs_fall) begin
          state_d = ST_SHIFT;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        // ncs rising wins over a coincident sclk edge.
        if (ncs_rise) begin
          state_d = ST_COMMIT;
        end else if (sclk_rise) begin
          shift_d = {shift_q[14:0], copi_s};
          if (cnt_q != CNT_TOP) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (frame_ok) begin
          frame_done = 1'b1;
          if (is_wr) begin
            unique case (1'b1)
              (addr == ADDR_EN_OUT_LO): r0_d = data;
              (addr == ADDR_EN_OUT_HI): r1_d = data;
              (addr == ADDR_EN_PWM_LO): r2_d = data;
              (addr == ADDR_EN_PWM_HI): r3_d = data;
              (addr == ADDR_PWM_DUTY):  r4_d = data;
              default: ;
            endcase
          end
        end else begin
          frame_err = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      copi_q  <= '0;
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      r0_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      r3_q    <= '0;
      r4_q    <= '0;
    end else begin
      copi_q  <= copi_d;
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      r3_q    <= r3_d;
      r4_q    <= r4_d;
    end
  end

  assign en_out_lo = r0_q;
  assign en_out_hi = r1_q;
  assign en_pwm_lo = r2_q;
  assign en_pwm_hi = r3_q;
  assign pwm_duty  = r4_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: directed and random SPI frames
// against a register-bank reference model.
module tb_spi_reg_ctrl;

  localparam int SYNC = 2;
  localparam int MAXA = 4;

  typedef struct packed {
    logic        is_err;
    logic [39:0] regs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ncs = 1'b1;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic [7:0] en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, pwm_duty;
  logic       frame_done, frame_err;

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   rise_time = 0;
  exp_t exp_q[$];
  logic [7:0] mregs [5];

  logic        pend = 1'b0;
  logic [39:0] pend_regs = '0;

  spi_reg_ctrl #(
    .SYNC_STAGES (SYNC),
    .MAX_ADDR    (MAXA)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ncs_i      (ncs),
    .sclk_i     (sclk),
    .copi_i     (copi),
    .en_out_lo  (en_out_lo),
    .en_out_hi  (en_out_hi),
    .en_pwm_lo  (en_pwm_lo),
    .en_pwm_hi  (en_pwm_hi),
    .pwm_duty   (pwm_duty),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [39:0] dut_regs();
    return {pwm_duty, en_pwm_hi, en_pwm_lo, en_out_hi, en_out_lo};
  endfunction

  function automatic logic [39:0] model_regs();
    return {mregs[4], mregs[3], mregs[2], mregs[1], mregs[0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: pops one expectation per status pulse, then checks the
  // register bank one cycle later, once the commit edge has passed.
  always @(negedge clk) begin
    if (!rst) begin
      if (pend) begin
        chk("regs_after_frame", {24'd0, dut_regs()}, {24'd0, pend_regs});
        chk("latency_le_sync_plus_2",
            64'((cyc - rise_time) <= SYNC + 2), 64'd1);
        pend <= 1'b0;
      end
      if (frame_done || frame_err) begin
        chk("done_err_exclusive", {63'd0, frame_done & frame_err}, 64'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {62'd0, frame_done, frame_err}, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pulse_kind", {62'd0, frame_done, frame_err},
              {62'd0, ~e.is_err, e.is_err});
          pend      <= 1'b1;
          pend_regs <= e.regs;
        end
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = bits[i];
      wait_clks(4);
      sclk = 1'b1;
      wait_clks(4);
      sclk = 1'b0;
    end
  endtask

  // Reference model: a frame is accepted only with exactly 16 bits and
  // an address within range; accepted writes update the bank.
  task automatic issue(input logic [31:0] bits, input int n);
    exp_t e;
    logic [6:0] a;
    a = bits[14:8];
    e.is_err = !(n == 16 && int'(a) <= MAXA);
    if (!e.is_err && bits[15] && a < 7'd5) mregs[a[2:0]] = bits[7:0];
    e.regs = model_regs();
    exp_q.push_back(e);
    ncs = 1'b0;
    wait_clks(4);
    shift_bits(bits, n);
    wait_clks(4);
    ncs = 1'b1;
    rise_time = cyc;
    wait_clks(10);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) mregs[i] = 8'h00;
    wait_clks(5);
    rst = 1'b0;
    wait_clks(6);
    chk("reset_regs", {24'd0, dut_regs()}, 64'd0);
    chk("reset_pulses", {62'd0, frame_done, frame_err}, 64'd0);

    issue(32'h80F0, 16);
    issue(32'h8480, 16);
    issue(32'h85AA, 16);
    issue(32'h8155 >> 1, 15);
    issue(32'h8155 << 1, 17);
    issue(32'h823C, 16);
    issue(32'h0200, 16);
    issue(32'hC411, 16);

    for (int k = 0; k < 30; k++) begin
      logic [31:0] b;
      int n;
      b = $urandom;
      b[14:8] = ($urandom_range(0, 9) == 0) ? 7'h44
                                           : 7'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: n = 15;
        1: n = 17;
        default: n = 16;
      endcase
      if (n == 17) b = {b[30:0], 1'b1};
      if (n == 15) b = b >> 1;
      issue(b, n);
    end

    // Reset during a write to address 3, released with ncs still low.
    ncs = 1'b0;
    wait_clks(4);
    shift_bits(32'h83, 8);
    rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) mregs[i] = 8'h00;
    wait_clks(12);
    chk("mid_frame_reset_regs", {24'd0, dut_regs()}, 64'd0);
    ncs = 1'b1;
    wait_clks(10);

    issue(32'h835A, 16);
    for (int k = 0; k < 5; k++) issue({16'd0, 1'b1, 7'($urandom_range(0, 4)), 8'($urandom)}, 16);

    for (int t = 0; t < 100 && (exp_q.size() != 0 || pend); t++) wait_clks(1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
